wb_stage: RTL and testbench
===========================

WB_STAGE -- requirements
Module: wb_stage

Interface
REQ-001 SHALL have parameter DATA_W, default 32, meaning the data and register width.
REQ-002 SHALL have parameter ADDR_W, default 5, meaning the register address width (32 registers).
REQ-003 SHALL have port clk, input, 1, the clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1, reset; reset rst, synchronous, active-high.
REQ-005 SHALL have port flush, input, 1, cancels any pending load and blocks acceptance this cycle.
REQ-006 SHALL have port in_valid, input, 1, upstream MEM-stage result valid.
REQ-007 SHALL have port in_ready, output, 1, stage can accept; combinational, equal to (state==IDLE && !flush).
REQ-008 SHALL have port in_wen, input, 1, instruction writes a register.
REQ-009 SHALL have port in_waddr, input, ADDR_W, destination register.
REQ-010 SHALL have port in_result, input, DATA_W, ALU/non-load result.
REQ-011 SHALL have port in_is_load, input, 1, the result comes from memory.
REQ-012 SHALL have port in_ld_size, input, 2, load size: 0=byte, 1=half, 2=word, 3=word.
REQ-013 SHALL have port in_ld_unsigned, input, 1, zero-extend (1) or sign-extend (0).
REQ-014 SHALL have port in_byte_off, input, 2, address bits [1:0] of the load.
REQ-015 SHALL have port mem_rvalid, input, 1, load data valid.
REQ-016 SHALL have port mem_rdata, input, DATA_W, load data word, little-endian lanes.
REQ-017 SHALL have port rf_write, output, 1, register file write enable (registered).
REQ-018 SHALL have port rf_waddr, output, ADDR_W, register file write address (registered).
REQ-019 SHALL have port rf_din, output, DATA_W, register file write data (registered).
REQ-020 SHALL have port pend_valid, output, 1, a load is outstanding (state==WAIT_LOAD).
REQ-021 SHALL have port pend_addr, output, ADDR_W, destination of the outstanding load; 0 when pend_valid=0.
REQ-022 SHALL have port retire_cnt, output, 32, count of register writes performed, wraps modulo 2^32.

Function
REQ-023 SHALL implement FSM states IDLE and WAIT_LOAD; accept = in_valid && in_ready.
REQ-024 On accept with in_is_load=0: next cycle rf_write=in_wen, rf_waddr=in_waddr, rf_din=in_result; state stays IDLE (1-cycle latency).
REQ-025 On accept with in_is_load=1: latch waddr/wen/size/unsigned/offset, go to WAIT_LOAD; rf_write=0 next cycle.
REQ-026 In WAIT_LOAD with mem_rvalid=1 and flush=0: next cycle rf_write=latched wen, rf_din=aligned data, state returns to IDLE.
REQ-027 Byte load: lane = mem_rdata[8*off+7:8*off]; half load: lane = mem_rdata[15:0] if off[1]=0 else [31:16], off[0] ignored; word load: off ignored.
REQ-028 Extension: unsigned pads zeros; signed replicates lane MSB to DATA_W.
REQ-029 rf_write SHALL be a single-cycle pulse per write; deasserted in all other cycles, with rf_waddr/rf_din held at their last values.
REQ-030 mem_rvalid SHALL be ignored in IDLE, including the acceptance cycle of a load.
REQ-031 flush in WAIT_LOAD SHALL return to IDLE with no write, even if mem_rvalid=1 that cycle; a rf_write already registered is not retracted.
REQ-032 Back-to-back: an instruction is accepted in the same cycle the previous write's rf_write is high.
REQ-033 retire_cnt SHALL increment by 1 in the cycle rf_write=1; 0xFFFFFFFF wraps to 0.

Reset
REQ-034 With rst=1 at a clock edge: state=IDLE, rf_write=0, rf_waddr=0, rf_din=0, pend_addr=0, retire_cnt=0; rst overrides accept, mem_rvalid and flush.
REQ-035 Reset during WAIT_LOAD SHALL discard the load; a subsequent mem_rvalid produces no write.

Verification
REQ-036 ALU: accept wen=1, waddr=3, result=0x12345678 -> next cycle rf_write=1, waddr=3, din=0x12345678, retire_cnt=1.
REQ-037 Signed byte: load size=0, off=2, unsigned=0, waddr=7; 2 cycles later mem_rdata=0x00F10000 -> cycle after: din=0xFFFFFFF1, pend_valid=1 until then.
REQ-038 Unsigned half: size=1, off=3, rdata=0xBEEF0000 -> din=0x0000BEEF; signed -> 0xFFFFBEEF.
REQ-039 Flush: load pending, flush=1 with mem_rvalid=1 -> no rf_write, state IDLE, in_ready=1 next cycle.
REQ-040 Reset mid-load and counter wrap: rst in WAIT_LOAD then mem_rvalid -> no write; retire_cnt forced to 0xFFFFFFFF then one write -> 0.

Source files
------------

// File: rtl/wb_stage.sv
// Write-back stage: retires ALU results in one cycle and aligns/extends load data
// returned from memory before writing the register file.
module wb_stage #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned ADDR_W = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              in_wen,
  input  logic [ADDR_W-1:0] in_waddr,
  input  logic [DATA_W-1:0] in_result,
  input  logic              in_is_load,
  input  logic [1:0]        in_ld_size,
  input  logic              in_ld_unsigned,
  input  logic [1:0]        in_byte_off,
  input  logic              mem_rvalid,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              rf_write,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_din,
  output logic              pend_valid,
  output logic [ADDR_W-1:0] pend_addr,
  output logic [31:0]       retire_cnt
);

  localparam int unsigned CNT_W = 32;

  typedef enum logic {
    IDLE      = 1'b0,
    WAIT_LOAD = 1'b1
  } state_e;

  state_e              state_q, state_d;
  logic                rf_write_q, rf_write_d;
  logic [ADDR_W-1:0]   rf_waddr_q, rf_waddr_d;
  logic [DATA_W-1:0]   rf_din_q, rf_din_d;
  logic [ADDR_W-1:0]   pend_addr_q, pend_addr_d;
  logic [CNT_W-1:0]    retire_cnt_q, retire_cnt_d;
  logic                ld_wen_q, ld_wen_d;
  logic [1:0]          ld_size_q, ld_size_d;
  logic                ld_uns_q, ld_uns_d;
  logic [1:0]          ld_off_q, ld_off_d;

  logic                accept;
  logic [7:0]          byte_lane;
  logic [15:0]         half_lane;
  logic [DATA_W-1:0]   load_data;

  assign in_ready   = (state_q == IDLE) && !flush;
  assign accept     = in_valid && in_ready;
  assign rf_write   = rf_write_q;
  assign rf_waddr   = rf_waddr_q;
  assign rf_din     = rf_din_q;
  assign pend_valid = (state_q == WAIT_LOAD);
  assign pend_addr  = pend_addr_q;
  assign retire_cnt = retire_cnt_q;

  // Lane selection and extension of the returned load word.
  always_comb begin
    byte_lane = mem_rdata[{ld_off_q, 3'b000} +: 8];
    half_lane = ld_off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (ld_size_q)
      2'd0:    load_data = ld_uns_q ? DATA_W'(byte_lane)
                                    : {{(DATA_W-8){byte_lane[7]}}, byte_lane};
      2'd1:    load_data = ld_uns_q ? DATA_W'(half_lane)
                                    : {{(DATA_W-16){half_lane[15]}}, half_lane};
      default: load_data = mem_rdata;
    endcase
  end

  // Next-state logic; address/data only move when a write actually happens.
  always_comb begin
    state_d     = state_q;
    rf_write_d  = 1'b0;
    rf_waddr_d  = rf_waddr_q;
    rf_din_d    = rf_din_q;
    pend_addr_d = pend_addr_q;
    ld_wen_d    = ld_wen_q;
    ld_size_d   = ld_size_q;
    ld_uns_d    = ld_uns_q;
    ld_off_d    = ld_off_q;

    case (state_q)
      IDLE: begin
        if (accept) begin
          if (in_is_load) begin
            state_d     = WAIT_LOAD;
            pend_addr_d = in_waddr;
            ld_wen_d    = in_wen;
            ld_size_d   = in_ld_size;
            ld_uns_d    = in_ld_unsigned;
            ld_off_d    = in_byte_off;
          end else if (in_wen) begin
            rf_write_d = 1'b1;
            rf_waddr_d = in_waddr;
            rf_din_d   = in_result;
          end
        end
      end
      WAIT_LOAD: begin
        if (flush) begin
          state_d     = IDLE;
          pend_addr_d = '0;
        end else if (mem_rvalid) begin
          state_d     = IDLE;
          pend_addr_d = '0;
          if (ld_wen_q) begin
            rf_write_d = 1'b1;
            rf_waddr_d = pend_addr_q;
            rf_din_d   = load_data;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    retire_cnt_d = retire_cnt_q + CNT_W'(rf_write_d);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      rf_write_q   <= 1'b0;
      rf_waddr_q   <= '0;
      rf_din_q     <= '0;
      pend_addr_q  <= '0;
      retire_cnt_q <= '0;
      ld_wen_q     <= 1'b0;
      ld_size_q    <= 2'd0;
      ld_uns_q     <= 1'b0;
      ld_off_q     <= 2'd0;
    end else begin
      state_q      <= state_d;
      rf_write_q   <= rf_write_d;
      rf_waddr_q   <= rf_waddr_d;
      rf_din_q     <= rf_din_d;
      pend_addr_q  <= pend_addr_d;
      retire_cnt_q <= retire_cnt_d;
      ld_wen_q     <= ld_wen_d;
      ld_size_q    <= ld_size_d;
      ld_uns_q     <= ld_uns_d;
      ld_off_q     <= ld_off_d;
    end
  end

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the write-back rules.
module tb_wb_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, in_wen, in_is_load, in_ld_unsigned, mem_rvalid;
  logic [4:0]  in_waddr;
  logic [31:0] in_result, mem_rdata;
  logic [1:0]  in_ld_size, in_byte_off;
  logic        in_ready, rf_write, pend_valid;
  logic [4:0]  rf_waddr, pend_addr;
  logic [31:0] rf_din, retire_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_stage #(.DATA_W(32), .ADDR_W(5)) dut (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
    .in_wen(in_wen), .in_waddr(in_waddr), .in_result(in_result),
    .in_is_load(in_is_load), .in_ld_size(in_ld_size), .in_ld_unsigned(in_ld_unsigned),
    .in_byte_off(in_byte_off), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .rf_write(rf_write), .rf_waddr(rf_waddr), .rf_din(rf_din),
    .pend_valid(pend_valid), .pend_addr(pend_addr), .retire_cnt(retire_cnt)
  );

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    flush = 0; in_valid = 0; in_wen = 0; in_waddr = 0; in_result = 0;
    in_is_load = 0; in_ld_size = 0; in_ld_unsigned = 0; in_byte_off = 0;
    mem_rvalid = 0; mem_rdata = 0;
  endtask

  task automatic issue_alu(input bit wen, input logic [4:0] a, input logic [31:0] r);
    in_valid = 1; in_is_load = 0; in_wen = wen; in_waddr = a; in_result = r;
  endtask

  task automatic issue_load(input logic [4:0] a, input logic [1:0] sz, input bit uns,
                            input logic [1:0] off);
    in_valid = 1; in_is_load = 1; in_wen = 1; in_waddr = a;
    in_ld_size = sz; in_ld_unsigned = uns; in_byte_off = off;
  endtask

  // Load extraction from the rules: pick the lane by shifting, then extend.
  function automatic logic [31:0] ref_load(input logic [31:0] w, input int sz,
                                           input bit uns, input int off);
    logic [31:0] v;
    int bits;
    if (sz == 0) begin
      v = (w >> (8 * off)) & 32'h0000_00FF; bits = 8;
    end else if (sz == 1) begin
      v = (w >> (16 * (off / 2))) & 32'h0000_FFFF; bits = 16;
    end else begin
      return w;
    end
    if (!uns && v[bits-1]) v = v | (32'hFFFF_FFFF << bits);
    return v;
  endfunction

  task automatic test_reset();
    clear_inputs();
    rst = 1; in_valid = 1; in_wen = 1; in_waddr = 5'd9; in_result = 32'hDEAD; mem_rvalid = 1;
    cyc(); cyc();
    rst = 0; clear_inputs(); #1;
    checks++;
    if (rf_write !== 1'b0 || rf_waddr !== 5'd0 || rf_din !== 32'd0 || pend_valid !== 1'b0 ||
        pend_addr !== 5'd0 || retire_cnt !== 32'd0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset: write=%b waddr=%0d din=%h pv=%b pa=%0d cnt=%0d rdy=%b (want all 0, rdy=1)",
               rf_write, rf_waddr, rf_din, pend_valid, pend_addr, retire_cnt, in_ready);
    end
  endtask

  task automatic test_alu();
    issue_alu(1, 5'd3, 32'h1234_5678);
    cyc(); clear_inputs();
    checks++;
    if (rf_write !== 1'b1 || rf_waddr !== 5'd3 || rf_din !== 32'h1234_5678 || retire_cnt !== 32'd1) begin
      errors++;
      $display("FAIL alu_write: write=%b waddr=%0d din=%h cnt=%0d want 1 3 12345678 1",
               rf_write, rf_waddr, rf_din, retire_cnt);
    end
    cyc();
    checks++;
    if (rf_write !== 1'b0 || rf_waddr !== 5'd3 || rf_din !== 32'h1234_5678 || retire_cnt !== 32'd1) begin
      errors++;
      $display("FAIL alu_pulse_hold: write=%b waddr=%0d din=%h cnt=%0d want 0 3 12345678 1",
               rf_write, rf_waddr, rf_din, retire_cnt);
    end
  endtask

  task automatic test_signed_byte();
    issue_load(5'd7, 2'd0, 0, 2'd2);
    mem_rvalid = 1; mem_rdata = 32'h0080_0000;
    cyc(); clear_inputs();
    checks++;
    if (rf_write !== 1'b0 || pend_valid !== 1'b1 || pend_addr !== 5'd7 || in_ready !== 1'b0) begin
      errors++;
      $display("FAIL load_accept: write=%b pv=%b pa=%0d rdy=%b want 0 1 7 0",
               rf_write, pend_valid, pend_addr, in_ready);
    end
    cyc();
    mem_rvalid = 1; mem_rdata = 32'h00F1_0000;
    checks++;
    if (pend_valid !== 1'b1 || rf_write !== 1'b0) begin
      errors++;
      $display("FAIL load_wait: pv=%b write=%b want 1 0", pend_valid, rf_write);
    end
    cyc(); clear_inputs();
    checks++;
    if (rf_write !== 1'b1 || rf_waddr !== 5'd7 || rf_din !== 32'hFFFF_FFF1 ||
        pend_valid !== 1'b0 || pend_addr !== 5'd0 || retire_cnt !== 32'd2) begin
      errors++;
      $display("FAIL signed_byte: write=%b waddr=%0d din=%h pv=%b pa=%0d cnt=%0d want 1 7 fffffff1 0 0 2",
               rf_write, rf_waddr, rf_din, pend_valid, pend_addr, retire_cnt);
    end
  endtask

  task automatic test_half();
    for (int u = 1; u >= 0; u--) begin
      issue_load(5'd9, 2'd1, bit'(u), 2'd3);
      cyc(); clear_inputs();
      mem_rvalid = 1; mem_rdata = 32'hBEEF_0000;
      cyc(); clear_inputs();
      checks++;
      if (rf_write !== 1'b1 || rf_waddr !== 5'd9 ||
          rf_din !== (u == 1 ? 32'h0000_BEEF : 32'hFFFF_BEEF)) begin
        errors++;
        $display("FAIL half_uns%0d: write=%b waddr=%0d din=%h", u, rf_write, rf_waddr, rf_din);
      end
    end
    checks++;
    if (retire_cnt !== 32'd4) begin
      errors++;
      $display("FAIL half_count: cnt=%0d want 4", retire_cnt);
    end
  endtask

  task automatic test_flush();
    issue_load(5'd5, 2'd2, 0, 2'd0);
    cyc(); clear_inputs();
    flush = 1; mem_rvalid = 1; mem_rdata = 32'hCAFE_F00D;
    #1;
    checks++;
    if (in_ready !== 1'b0) begin
      errors++;
      $display("FAIL flush_ready_comb: rdy=%b want 0", in_ready);
    end
    cyc(); clear_inputs(); #1;
    checks++;
    if (rf_write !== 1'b0 || pend_valid !== 1'b0 || in_ready !== 1'b1 || retire_cnt !== 32'd4) begin
      errors++;
      $display("FAIL flush_load: write=%b pv=%b rdy=%b cnt=%0d want 0 0 1 4",
               rf_write, pend_valid, in_ready, retire_cnt);
    end
  endtask

  task automatic test_reset_mid_load();
    issue_load(5'd12, 2'd2, 0, 2'd0);
    cyc(); clear_inputs();
    rst = 1;
    cyc(); rst = 0;
    checks++;
    if (pend_valid !== 1'b0 || retire_cnt !== 32'd0 || rf_waddr !== 5'd0 || rf_din !== 32'd0) begin
      errors++;
      $display("FAIL reset_mid_load: pv=%b cnt=%0d waddr=%0d din=%h want 0 0 0 0",
               pend_valid, retire_cnt, rf_waddr, rf_din);
    end
    mem_rvalid = 1; mem_rdata = 32'h5555_AAAA;
    cyc(); clear_inputs();
    checks++;
    if (rf_write !== 1'b0 || retire_cnt !== 32'd0) begin
      errors++;
      $display("FAIL stale_rvalid: write=%b cnt=%0d want 0 0", rf_write, retire_cnt);
    end
  endtask

  task automatic test_wrap();
    force dut.retire_cnt_q = 32'hFFFF_FFFF;
    #1;
    release dut.retire_cnt_q;
    #1;
    checks++;
    if (retire_cnt !== 32'hFFFF_FFFF) begin
      errors++;
      $display("FAIL wrap_preset: cnt=%h want ffffffff", retire_cnt);
    end
    issue_alu(1, 5'd1, 32'h0000_0001);
    cyc(); clear_inputs();
    checks++;
    if (rf_write !== 1'b1 || retire_cnt !== 32'd0) begin
      errors++;
      $display("FAIL wrap: write=%b cnt=%h want 1 00000000", rf_write, retire_cnt);
    end
  endtask

  task automatic test_back_to_back();
    issue_alu(1, 5'd20, 32'hAAAA_0001);
    cyc();
    issue_alu(1, 5'd21, 32'hAAAA_0002);
    #1;
    checks++;
    if (rf_write !== 1'b1 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL b2b_ready: write=%b rdy=%b want 1 1", rf_write, in_ready);
    end
    cyc();
    issue_load(5'd22, 2'd0, 1, 2'd1);
    checks++;
    if (rf_write !== 1'b1 || rf_waddr !== 5'd21 || rf_din !== 32'hAAAA_0002 || retire_cnt !== 32'd2) begin
      errors++;
      $display("FAIL b2b_second: write=%b waddr=%0d din=%h cnt=%0d want 1 21 aaaa0002 2",
               rf_write, rf_waddr, rf_din, retire_cnt);
    end
    cyc(); clear_inputs();
    checks++;
    if (rf_write !== 1'b0 || pend_valid !== 1'b1 || pend_addr !== 5'd22) begin
      errors++;
      $display("FAIL b2b_load: write=%b pv=%b pa=%0d want 0 1 22", rf_write, pend_valid, pend_addr);
    end
    mem_rvalid = 1; mem_rdata = 32'h0000_9C00;
    cyc(); clear_inputs();
    checks++;
    if (rf_write !== 1'b1 || rf_din !== 32'h0000_009C || retire_cnt !== 32'd3) begin
      errors++;
      $display("FAIL b2b_load_data: write=%b din=%h cnt=%0d want 1 0000009c 3",
               rf_write, rf_din, retire_cnt);
    end
  endtask

  task automatic test_random();
    bit          m_pend, m_wen, m_uns, m_known, exp_w, exp_rdy;
    logic [4:0]  m_addr, m_last_addr;
    logic [1:0]  m_size, m_off;
    logic [31:0] m_cnt, m_last_din;
    clear_inputs();
    rst = 1; cyc(); rst = 0;
    m_pend = 0; m_wen = 0; m_uns = 0; m_addr = 0; m_size = 0; m_off = 0;
    m_cnt = 0; m_last_addr = 0; m_last_din = 0; m_known = 1;
    for (int n = 0; n < 600; n++) begin
      rst            = ($urandom_range(0, 49) == 0);
      flush          = ($urandom_range(0, 9) == 0);
      in_valid       = $urandom_range(0, 1) == 1;
      in_wen         = ($urandom_range(0, 5) != 0);
      in_waddr       = 5'($urandom);
      in_result      = $urandom;
      in_is_load     = $urandom_range(0, 1) == 1;
      in_ld_size     = 2'($urandom);
      in_ld_unsigned = $urandom_range(0, 1) == 1;
      in_byte_off    = 2'($urandom);
      mem_rvalid     = ($urandom_range(0, 4) < 2);
      mem_rdata      = $urandom;
      #1;
      exp_rdy = !m_pend && !flush;
      checks++;
      if (in_ready !== exp_rdy) begin
        errors++;
        $display("FAIL rand_ready[%0d]: got %b want %b", n, in_ready, exp_rdy);
      end
      exp_w = 0;
      if (rst) begin
        m_pend = 0; m_cnt = 0; m_last_addr = 0; m_last_din = 0; m_known = 1;
      end else if (m_pend) begin
        if (flush) m_pend = 0;
        else if (mem_rvalid) begin
          m_pend = 0;
          if (m_wen) begin
            exp_w = 1; m_last_addr = m_addr;
            m_last_din = ref_load(mem_rdata, int'(m_size), m_uns, int'(m_off));
            m_known = 1;
          end
        end
      end else if (in_valid && !flush) begin
        if (in_is_load) begin
          m_pend = 1; m_wen = in_wen; m_addr = in_waddr;
          m_size = in_ld_size; m_uns = in_ld_unsigned; m_off = in_byte_off;
        end else if (in_wen) begin
          exp_w = 1; m_last_addr = in_waddr; m_last_din = in_result; m_known = 1;
        end else begin
          m_known = 0;
        end
      end
      if (exp_w) m_cnt = m_cnt + 32'd1;
      cyc();
      checks++;
      if (rf_write !== exp_w || pend_valid !== m_pend || retire_cnt !== m_cnt ||
          pend_addr !== (m_pend ? m_addr : 5'd0)) begin
        errors++;
        $display("FAIL rand_ctrl[%0d]: write=%b/%b pv=%b/%b pa=%0d cnt=%0d/%0d",
                 n, rf_write, exp_w, pend_valid, m_pend, pend_addr, retire_cnt, m_cnt);
      end
      if (m_known) begin
        checks++;
        if (rf_waddr !== m_last_addr || rf_din !== m_last_din) begin
          errors++;
          $display("FAIL rand_data[%0d]: waddr=%0d want %0d din=%h want %h",
                   n, rf_waddr, m_last_addr, rf_din, m_last_din);
        end
      end
    end
    clear_inputs(); rst = 0;
  endtask

  initial begin
    rst = 1;
    clear_inputs();
    test_reset();
    test_alu();
    test_signed_byte();
    test_half();
    test_flush();
    test_reset_mid_load();
    test_wrap();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
